// File: rtl/clkbuf_branch_sequencer.sv
// Staggered enable sequencer for N gated clock-buffer branches.
// Ports: CLK/RN clock and async reset, REQ/ACK level handshake,
//   MASK branch exclusion (captured on wake), EN gate enables,
//   BUSY high while ramping. All outputs come straight from flops.
module clkbuf_branch_sequencer #(
  parameter int N_BRANCH = 4,
  parameter int STAGGER  = 3,
  parameter int CNT_W    = 4
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic                REQ,
  input  logic [N_BRANCH-1:0] MASK,
  output logic [N_BRANCH-1:0] EN,
  output logic                ACK,
  output logic                BUSY
);

  localparam int PTR_W = $clog2(N_BRANCH + 1);

  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_BRANCH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STAGGER - 1);

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_UP  = 2'd1;
  localparam logic [1:0] S_ON  = 2'd2;
  localparam logic [1:0] S_DN  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BRANCH-1:0] raw_q, raw_d;
  logic [N_BRANCH-1:0] mask_q, mask_d;
  logic [N_BRANCH-1:0] en_q, en_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;

  logic                do_up;
  logic                do_dn;
  logic                cnt_nz;
  logic [N_BRANCH-1:0] set_m;
  logic [N_BRANCH-1:0] clr_m;

  assign cnt_nz = (cnt_q != '0);

  // Branch selected by an up-step is ptr, by a down-step ptr-1.
  always_comb begin
    set_m = '0;
    clr_m = '0;
    for (int i = 0; i < N_BRANCH; i++) begin
      set_m[i] = (PTR_W'(i) == ptr_q);
      clr_m[i] = (PTR_W'(i + 1) == ptr_q);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    mask_d  = mask_q;
    ack_d   = ack_q;
    do_up   = 1'b0;
    do_dn   = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (REQ) begin
          state_d = S_UP;
          mask_d  = MASK;
          do_up   = 1'b1;
        end
      end
      S_UP: begin
        // A reversal takes no step; the running stagger
        // interval is honoured before the first down-step.
        if (!REQ) begin
          state_d = S_DN;
          if (cnt_nz) cnt_d = cnt_q - 1'b1;
        end else if (cnt_nz) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ptr_q != PTR_MAX) begin
          do_up = 1'b1;
        end else begin
          state_d = S_ON;
          ack_d   = 1'b1;
        end
      end
      S_ON: begin
        if (!REQ) begin
          state_d = S_DN;
          do_dn   = 1'b1;
        end
      end
      S_DN: begin
        if (REQ) begin
          state_d = S_UP;
          if (cnt_nz) cnt_d = cnt_q - 1'b1;
        end else if (cnt_nz) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ptr_q != '0) begin
          do_dn = 1'b1;
        end else begin
          state_d = S_OFF;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (do_up) begin
      raw_d = raw_q | set_m;
      ptr_d = ptr_q + 1'b1;
      cnt_d = CNT_LOAD;
    end
    if (do_dn) begin
      raw_d = raw_q & ~clr_m;
      ptr_d = ptr_q - 1'b1;
      cnt_d = CNT_LOAD;
    end
  end

  assign en_d   = raw_d & ~mask_d;
  assign busy_d = (state_d == S_UP) || (state_d == S_DN);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_OFF;
      ptr_q   <= '0;
      cnt_q   <= '0;
      raw_q   <= '0;
      mask_q  <= '0;
      en_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign EN   = en_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule
